// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet receive path: controller state
// encoding, 11-bit frame index type, fixed header offsets and the largest
// legal frame index (1518-byte frame without CRC).
// ---------------------------------------------------------------------------
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_STREAM = 2'd2,
    ST_FLUSH  = 2'd3
  } rx_state_e;

  localparam int unsigned IDX_W = 11;
  typedef logic [IDX_W-1:0] idx_t;

  // Header layout: destination MAC at byte 0, EtherType at bytes 12..13,
  // payload starts right after the 14-byte header.
  localparam idx_t DST_OFF       = 11'd0;
  localparam idx_t TYPE_OFF      = 11'd12;
  localparam idx_t PAYLOAD_OFF   = 11'd14;
  localparam idx_t MAX_FRAME_IDX = 11'd1517;

  // Limits a reported last-byte index to the physical buffer.
  function automatic idx_t clamp_idx(input idx_t a);
    return (a > MAX_FRAME_IDX) ? MAX_FRAME_IDX : a;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that increments by one per cycle of inc and sticks at its
// all-ones value instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   count : current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    // NOTE: assign a default before any condition so no latch is inferred.
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: reset is sampled on the clock edge and wins over any update;
  // non-blocking assignments make every flop see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// rx_pkt_ctrl
// Filters a received frame on destination MAC (unicast or broadcast),
// EtherType and minimum length, then streams its payload bytes out as a
// valid/ready byte stream. A new doorbell while a frame is in flight aborts
// it with a single error beat.
//   clk, rst            : clock, synchronous active-high reset
//   pktbuf              : frame bytes, byte 0 first on the wire
//   pktbuf_maxaddr      : index of last valid byte (CRC stripped)
//   doorbell            : one-cycle pulse, a new frame is in pktbuf
//   my_mac              : station address, [47:40] matches byte 0
//   axiov/axiod/axiolast/axioerr, axioready : payload byte stream
//   busy                : controller not idle
//   ok/drop/overrun_count : saturating event counters
// ---------------------------------------------------------------------------
module rx_pkt_ctrl
  import eth_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned MIN_PAYLOAD = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MAX_FRAME_IDX:0][7:0] pktbuf,
  input  logic [IDX_W-1:0]            pktbuf_maxaddr,
  input  logic                        doorbell,
  input  logic [47:0]                 my_mac,
  output logic                        axiov,
  output logic [7:0]                  axiod,
  output logic                        axiolast,
  output logic                        axioerr,
  input  logic                        axioready,
  output logic                        busy,
  output logic [15:0]                 ok_count,
  output logic [15:0]                 drop_count,
  output logic [15:0]                 overrun_count
);

  // Smallest last-byte index that still carries MIN_PAYLOAD payload bytes.
  localparam idx_t MIN_MAXADDR = PAYLOAD_OFF - 11'd1 + 11'(MIN_PAYLOAD);

  rx_state_e  state_q, state_d;
  idx_t       idx_q, idx_d;
  idx_t       maxaddr_q, maxaddr_d;
  logic       axiov_q, axiov_d;
  logic [7:0] axiod_q, axiod_d;
  logic       axiolast_q, axiolast_d;
  logic       axioerr_q, axioerr_d;

  logic        ok_inc, drop_inc, ovr_inc;
  logic        handshake;
  logic        frame_ok;
  logic [47:0] dst_addr;
  logic [15:0] eth_type;
  idx_t        idx_next;

  assign dst_addr = {pktbuf[DST_OFF],         pktbuf[DST_OFF + 11'd1],
                     pktbuf[DST_OFF + 11'd2], pktbuf[DST_OFF + 11'd3],
                     pktbuf[DST_OFF + 11'd4], pktbuf[DST_OFF + 11'd5]};
  assign eth_type = {pktbuf[TYPE_OFF], pktbuf[TYPE_OFF + 11'd1]};

  assign frame_ok = ((dst_addr == my_mac) || (dst_addr == 48'hFFFF_FFFF_FFFF)) &&
                    (eth_type == ETHERTYPE) &&
                    (maxaddr_q >= MIN_MAXADDR);

  assign handshake = axiov_q && axioready;
  assign idx_next  = idx_q + 11'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    maxaddr_d  = maxaddr_q;
    axiov_d    = axiov_q;
    axiod_d    = axiod_q;
    axiolast_d = axiolast_q;
    axioerr_d  = axioerr_q;
    ok_inc     = 1'b0;
    drop_inc   = 1'b0;
    ovr_inc    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (doorbell) begin
          maxaddr_d = clamp_idx(pktbuf_maxaddr);
          state_d   = ST_CHECK;
        end
      end

      ST_CHECK: begin
        ovr_inc = doorbell;
        if (!frame_ok) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end else if (doorbell) begin
          // Accepted frame already overwritten: report it as aborted.
          state_d    = ST_FLUSH;
          axiov_d    = 1'b1;
          axiod_d    = 8'h00;
          axiolast_d = 1'b1;
          axioerr_d  = 1'b1;
        end else begin
          state_d    = ST_STREAM;
          idx_d      = PAYLOAD_OFF;
          axiov_d    = 1'b1;
          axiod_d    = pktbuf[PAYLOAD_OFF];
          axiolast_d = (PAYLOAD_OFF == maxaddr_q);
          axioerr_d  = 1'b0;
        end
      end

      ST_STREAM: begin
        if (handshake && axiolast_q) begin
          // Frame completes normally; a colliding doorbell is only counted.
          ok_inc     = 1'b1;
          ovr_inc    = doorbell;
          state_d    = ST_IDLE;
          axiov_d    = 1'b0;
          axiolast_d = 1'b0;
        end else if (doorbell) begin
          ovr_inc    = 1'b1;
          state_d    = ST_FLUSH;
          axiov_d    = 1'b1;
          axiod_d    = 8'h00;
          axiolast_d = 1'b1;
          axioerr_d  = 1'b1;
        end else if (handshake) begin
          idx_d      = idx_next;
          axiod_d    = pktbuf[idx_next];
          axiolast_d = (idx_next == maxaddr_q);
        end
      end

      ST_FLUSH: begin
        ovr_inc = doorbell;
        if (handshake) begin
          state_d    = ST_IDLE;
          axiov_d    = 1'b0;
          axiolast_d = 1'b0;
          axioerr_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      maxaddr_q  <= '0;
      axiov_q    <= 1'b0;
      axiod_q    <= 8'h00;
      axiolast_q <= 1'b0;
      axioerr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      maxaddr_q  <= maxaddr_d;
      axiov_q    <= axiov_d;
      axiod_q    <= axiod_d;
      axiolast_q <= axiolast_d;
      axioerr_q  <= axioerr_d;
    end
  end

  assign axiov    = axiov_q;
  assign axiod    = axiod_q;
  assign axiolast = axiolast_q;
  assign axioerr  = axioerr_q;
  assign busy     = (state_q != ST_IDLE);

  sat_counter #(.W(16)) u_ok_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ok_inc),
    .count (ok_count)
  );

  sat_counter #(.W(16)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (drop_count)
  );

  sat_counter #(.W(16)) u_ovr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ovr_inc),
    .count (overrun_count)
  );

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_pkt_ctrl
// Frame-level reference model: each issued frame is classified from its
// header bytes, the expected payload beats are queued, and a monitor pops
// and compares them on every handshake. Counters are compared against the
// model after each frame.
// ---------------------------------------------------------------------------
module tb_rx_pkt_ctrl;

  localparam logic [15:0] ETYPE = 16'h88B5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1517:0][7:0]   pktbuf;
  logic [10:0]          pktbuf_maxaddr;
  logic                 doorbell;
  logic [47:0]          my_mac;
  logic                 axiov;
  logic [7:0]           axiod;
  logic                 axiolast;
  logic                 axioerr;
  logic                 axioready = 1'b1;
  logic                 busy;
  logic [15:0]          ok_count;
  logic [15:0]          drop_count;
  logic [15:0]          overrun_count;

  rx_pkt_ctrl #(.ETHERTYPE(ETYPE), .MIN_PAYLOAD(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .pktbuf         (pktbuf),
    .pktbuf_maxaddr (pktbuf_maxaddr),
    .doorbell       (doorbell),
    .my_mac         (my_mac),
    .axiov          (axiov),
    .axiod          (axiod),
    .axiolast       (axiolast),
    .axioerr        (axioerr),
    .axioready      (axioready),
    .busy           (busy),
    .ok_count       (ok_count),
    .drop_count     (drop_count),
    .overrun_count  (overrun_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       err;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    exp_first = -1;
  int    ready_mode = 0;  // 0: always ready, 1: toggle, 2: random, 3: never
  int    ok_m = 0, drop_m = 0, ovr_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       axioready = 1'b1;
      1:       axioready = ~axioready;
      2:       axioready = ($urandom_range(0, 3) != 0);
      default: axioready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Monitor: compares every handshaken beat with the scoreboard and checks
  // that stalled beats neither change nor disappear.
  logic  prev_v = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t prev_b;
  always @(negedge clk) begin
    beat_t cur, want;
    if (rst) begin
      prev_v     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      cur = '{d: axiod, last: axiolast, err: axioerr};
      if (axiov) begin
        if (prev_stall) check("stall_hold", 32'(cur), 32'(prev_b));
        if (!prev_v && exp_first >= 0) begin
          check("first_beat_latency", cyc, exp_first);
          exp_first = -1;
        end
        if (axioready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got d=0x%0h last=%0b err=%0b, expected no beat",
                     axiod, axiolast, axioerr);
          end else begin
            want = exp_q.pop_front();
            check("beat", 32'(cur), 32'(want));
          end
        end
        prev_stall = !axioready;
        prev_b     = cur;
      end else begin
        if (prev_stall) check("no_retract", axiov, 1);
        prev_stall = 1'b0;
      end
      prev_v = axiov;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int m);
    ready_mode = m;
    step();
  endtask

  // dst_kind: 0 = my_mac, 1 = broadcast, 2 = my_mac with one byte corrupted
  task automatic build_frame(input int dst_kind, input bit type_ok, input int maxaddr);
    logic [47:0] dst;
    for (int i = 0; i < 1518; i++) pktbuf[i] = 8'($urandom);
    case (dst_kind)
      1:       dst = '1;
      2:       dst = my_mac ^ (48'h1 << (8 * $urandom_range(0, 5)));
      default: dst = my_mac;
    endcase
    for (int i = 0; i < 6; i++) pktbuf[i] = dst[8*(5-i) +: 8];
    pktbuf[12] = type_ok ? ETYPE[15:8] : (ETYPE[15:8] ^ 8'h01);
    pktbuf[13] = ETYPE[7:0];
    pktbuf_maxaddr = 11'(maxaddr);
  endtask

  // Reference classification straight from the frame rules.
  function automatic bit model_accept(output int lim);
    bit uni = 1'b1;
    bit bc  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (pktbuf[i] != my_mac[8*(5-i) +: 8]) uni = 1'b0;
      if (pktbuf[i] != 8'hFF) bc = 1'b0;
    end
    lim = (int'(pktbuf_maxaddr) > 1517) ? 1517 : int'(pktbuf_maxaddr);
    return (uni || bc) && ({pktbuf[12], pktbuf[13]} == ETYPE) && (lim >= 14);
  endfunction

  task automatic push_beats(input int first, input int last_idx, input int lim);
    beat_t b;
    for (int i = first; i <= last_idx; i++) begin
      b.d    = pktbuf[i];
      b.last = (i == lim);
      b.err  = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      step();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_axiov_low"}, axiov, 0);
    check({tag, "_ok_count"}, ok_count, ok_m);
    check({tag, "_drop_count"}, drop_count, drop_m);
    check({tag, "_overrun_count"}, overrun_count, ovr_m);
    exp_q.delete();
  endtask

  task automatic send_frame(input string tag, input int dst_kind, input bit type_ok,
                            input int maxaddr);
    int lim;
    bit acc;
    build_frame(dst_kind, type_ok, maxaddr);
    acc = model_accept(lim);
    if (acc) begin
      push_beats(14, lim, lim);
      ok_m = sat_inc(ok_m);
    end else begin
      drop_m = sat_inc(drop_m);
    end
    doorbell = 1'b1;
    if (acc) exp_first = cyc + 2;
    step();
    doorbell = 1'b0;
    check({tag, "_busy_check"}, busy, 1);
    wait_idle(tag);
    exp_first = -1;
  endtask

  // Second doorbell lands in the cycle of the second payload handshake;
  // flush_db adds another in the cycle the error beat is accepted.
  task automatic send_overrun(input string tag, input int maxaddr, input bit flush_db);
    int    lim;
    bit    acc;
    beat_t b;
    set_mode(0);
    build_frame(0, 1'b1, maxaddr);
    acc = model_accept(lim);
    if (acc && (lim - 13) <= 2) begin
      push_beats(14, lim, lim);
      ok_m  = sat_inc(ok_m);
      ovr_m = sat_inc(ovr_m);
    end else if (acc) begin
      push_beats(14, 15, lim);
      b = '{d: 8'h00, last: 1'b1, err: 1'b1};
      exp_q.push_back(b);
      ovr_m = sat_inc(ovr_m);
      if (flush_db) ovr_m = sat_inc(ovr_m);
    end
    doorbell  = 1'b1;
    exp_first = cyc + 2;
    step();
    doorbell = 1'b0;
    step();
    step();
    doorbell = 1'b1;
    step();
    doorbell = flush_db;
    step();
    doorbell = 1'b0;
    wait_idle(tag);
    exp_first = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lim;
    bit acc;
    rst            = 1'b1;
    doorbell       = 1'b0;
    pktbuf         = '0;
    pktbuf_maxaddr = '0;
    my_mac         = 48'h02_11_22_33_44_55;
    repeat (3) step();

    // Reset state
    check("rst_axiov", axiov, 0);
    check("rst_axiod", axiod, 0);
    check("rst_axiolast", axiolast, 0);
    check("rst_axioerr", axioerr, 0);
    check("rst_busy", busy, 0);
    check("rst_ok", ok_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ovr", overrun_count, 0);
    rst = 1'b0;
    step();

    // Unicast, 4 payload beats, always ready
    set_mode(0);
    send_frame("unicast", 0, 1'b1, 17);

    // Broadcast, single beat, toggling ready
    set_mode(1);
    send_frame("bcast", 1, 1'b1, 14);

    // Each reject reason on its own
    set_mode(0);
    send_frame("bad_dst", 2, 1'b1, 20);
    send_frame("bad_type", 0, 1'b0, 20);
    send_frame("short", 0, 1'b1, 13);

    // Overruns: mid-frame, on final handshake, and again during flush
    send_overrun("ovr_mid", 23, 1'b0);
    send_overrun("ovr_final", 15, 1'b0);
    send_overrun("ovr_flush", 23, 1'b1);

    // Reset mid-stream; doorbell during reset is ignored
    set_mode(0);
    build_frame(0, 1'b1, 30);
    acc = model_accept(lim);
    if (acc) push_beats(14, lim, lim);
    doorbell  = 1'b1;
    exp_first = cyc + 2;
    step();
    doorbell = 1'b0;
    repeat (4) step();
    check("pre_rst_streaming", axiov, 1);
    rst      = 1'b1;
    doorbell = 1'b1;
    exp_q.delete();
    exp_first = -1;
    step();
    check("axiov_after_rst", axiov, 0);
    check("busy_after_rst", busy, 0);
    rst      = 1'b0;
    doorbell = 1'b0;
    ok_m = 0; drop_m = 0; ovr_m = 0;
    step();
    check("db_in_rst_ignored", busy, 0);
    check("ok_after_rst", ok_count, 0);
    check("ovr_after_rst", overrun_count, 0);
    send_frame("post_rst", 0, 1'b1, 20);

    // Randomised frames with random backpressure, one clamped length
    set_mode(2);
    for (int i = 0; i < 25; i++) begin
      if (i == 10) send_frame("clamp", 0, 1'b1, 2000);
      else send_frame("rand", $urandom_range(0, 3) % 3, ($urandom_range(0, 3) != 0),
                      $urandom_range(12, 40));
    end

    // Saturation of ok_count
    set_mode(0);
    force dut.u_ok_cnt.cnt_q = 16'hFFFE;
    step();
    release dut.u_ok_cnt.cnt_q;
    ok_m = 16'hFFFE;
    check("ok_preload", ok_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) send_frame("sat", 0, 1'b1, $urandom_range(14, 20));
    check("ok_saturated", ok_count, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_pkt_ctrl.md
RX_PKT_CTRL -- requirements
Module: rx_pkt_ctrl

Interface
REQ-001 Parameter: ETHERTYPE, 16'h88B5, accepted EtherType; frames with any other EtherType are dropped.
REQ-002 Parameter: MIN_PAYLOAD, 1, minimum payload bytes after the 14-byte header for a frame to be accepted.
REQ-003 Port: clk  in  1  system clock; the only clock.
REQ-004 Port: rst  in  1  reset; synchronous to clk, active-high.
REQ-005 Port: pktbuf  in  [1517:0][7:0]  received frame; byte 0 is the first byte on the wire.
REQ-006 Port: pktbuf_maxaddr  in  11  index of the last valid frame byte (inclusive), CRC already stripped.
REQ-007 Port: doorbell  in  1  one-cycle pulse; a complete, CRC-good frame is present in pktbuf.
REQ-008 Port: my_mac  in  48  station address; my_mac[47:40] compares to pktbuf[0].
REQ-009 Port: axiov / axiod / axiolast / axioerr  out  1/8/1/1  payload byte stream: valid, data, last byte, frame aborted.
REQ-010 Port: axioready  in  1  downstream accepts a beat when axiov && axioready.
REQ-011 Port: busy  out  1  high in any state other than IDLE.
REQ-012 Port: ok_count / drop_count / overrun_count  out  16 each  saturating event counters.

Function
REQ-013 States SHALL be IDLE, CHECK, STREAM and FLUSH.
REQ-014 IDLE: doorbell=1 SHALL latch pktbuf_maxaddr and go to CHECK on the next cycle; otherwise remain in IDLE.
REQ-015 CHECK (one cycle) SHALL accept the frame only if all three hold: bytes 0-5 equal my_mac or all 8'hFF; {byte12,byte13} == ETHERTYPE; latched maxaddr >= 13+MIN_PAYLOAD.
REQ-016 Accept SHALL set the read index to 14 and go to STREAM; reject SHALL increment drop_count and return to IDLE.
REQ-017 STREAM: axiov=1 and axiod=pktbuf[index], registered; the first beat is valid 2 cycles after doorbell.
REQ-018 On each handshake the index SHALL advance by 1; axiolast=1 exactly when index == latched maxaddr.
REQ-019 A handshake with axiolast=1 SHALL increment ok_count and go to IDLE, with axiov=0 on the following cycle.
REQ-020 With axioready=0, axiod, axiolast and axioerr SHALL hold stable and axiov SHALL stay high (no retraction).
REQ-021 doorbell in CHECK or STREAM SHALL increment overrun_count and move to FLUSH (from CHECK: FLUSH only if the frame was accepted; otherwise drop and return to IDLE).
REQ-022 FLUSH SHALL present one beat with axiov=1, axiolast=1, axioerr=1 and axiod=8'h00, hold it until handshake, then go to IDLE; the newer frame is not delivered.
REQ-023 doorbell in FLUSH, or in the same cycle as a final handshake, SHALL increment overrun_count only; no new frame is started.
REQ-024 Counters SHALL saturate at 16'hFFFF; every counter update is visible one cycle after its event.
REQ-025 axioerr SHALL be 0 on every beat except the FLUSH beat.
REQ-026 Index and latched maxaddr SHALL be 11 bits; inputs with maxaddr > 1517 SHALL be clamped to 1517.

Reset
REQ-027 rst=1 SHALL force state IDLE; axiov, axiod, axiolast, axioerr, busy, index, latched maxaddr and all counters to 0; highest priority.
REQ-028 rst asserted mid-STREAM SHALL abort the frame with no FLUSH beat and no counter update; doorbell during rst is ignored.

Structure
REQ-029 The state enum, the header offsets (DST=0, TYPE=12, PAYLOAD=14) and MAX_FRAME_IDX=1517 SHALL live in the shared package eth_pkg.
REQ-030 A single sub-module, sat_counter (16-bit saturating increment), SHALL be instantiated three times; all other logic is flat.

Verification
REQ-031 Unicast frame: dst=my_mac, type=ETHERTYPE, maxaddr=17, axioready=1 -> 4 beats, bytes 14..17, last on byte 17, first beat 2 cycles after doorbell, ok_count=1.
REQ-032 Broadcast frame, dst=FF:FF:FF:FF:FF:FF, maxaddr=14, axioready toggling 1/0 -> single beat held stable while stalled, axiolast=1, ok_count=1.
REQ-033 Wrong dst, wrong type, and maxaddr=13 (each separately) -> no axiov, drop_count=3.
REQ-034 Second doorbell after 2 of 10 payload beats -> error beat (axiolast=1, axioerr=1, axiod=0), overrun_count=1, ok_count unchanged.
REQ-035 rst pulsed mid-STREAM, then a valid frame -> axiov=0 the cycle after rst; next frame delivered in full, ok_count=1.
REQ-036 ok_count preloaded to 16'hFFFE, 3 good frames -> ok_count stops at 16'hFFFF.
